// File: rtl/instr_loader_pkg.sv
// Shared CPU definitions for the boot-time instruction loader.
package instr_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   localparam int INSTR_W         = 32;
   localparam int BYTES_PER_INSTR = 4;
   localparam int BYTE_W          = 8;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake from the host plus the instruction memory write port.
interface instr_loader_if;
   import instr_loader_pkg::*;

   logic               rx_valid;
   logic [BYTE_W-1:0]  rx_data;
   logic               rx_ready;
   logic               mem_we;
   logic [INSTR_W-1:0] mem_addr;
   logic [INSTR_W-1:0] mem_wdata;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/instr_loader.sv
// Assembles a little-endian byte stream into instruction words and writes them
// to consecutive instruction memory slots, holding the CPU in reset until done.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   instr_loader_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold
);

   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

   loader_state_t      state;
   loader_state_t      state_next;
   logic [ADDR_W:0]    count;
   logic [ADDR_W-1:0]  word_idx;
   logic [1:0]         byte_idx;
   logic [INSTR_W-1:0] asm_word;
   logic [INSTR_W-1:0] asm_next;

   logic can_start;
   logic too_big;
   logic start_ok;
   logic handshake;
   logic last_byte;
   logic last_word;

   assign can_start = (state == IDLE) || (state == DONE);
   assign too_big   = word_count > DEPTH_W;
   assign start_ok  = start && can_start && (word_count != '0) && !too_big;
   assign handshake = bus.rx_valid && bus.rx_ready;
   assign last_byte = byte_idx == LAST_BYTE;
   assign last_word = {1'b0, word_idx} == (count - (ADDR_W+1)'(1));

   // The incoming byte replaces its lane so the final word is ready the same cycle.
   always_comb begin
      asm_next = asm_word;
      asm_next[{byte_idx, 3'b000} +: BYTE_W] = bus.rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      bus.rx_ready = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      cpu_hold     = 1'b1;
      case (state)
         IDLE, DONE: begin
            done     = (state == DONE);
            cpu_hold = (state != DONE);
            if (start) begin
               if (word_count == '0) begin
                  state_next = DONE;
               end else if (!too_big) begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            bus.rx_ready = 1'b1;
            busy         = 1'b1;
            if (handshake && last_byte) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            busy       = 1'b1;
            state_next = last_word ? DONE : LOAD;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Write strobe, address and data are registered so they are stable for the
   // whole WRITE cycle; the memory captures them on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count         <= '0;
         word_idx      <= '0;
         byte_idx      <= '0;
         asm_word      <= '0;
         err           <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         err        <= start && can_start && too_big;
         if (start_ok) begin
            count    <= word_count;
            word_idx <= '0;
            byte_idx <= '0;
         end
         if (state == LOAD && handshake) begin
            asm_word <= asm_next;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
               bus.mem_we    <= 1'b1;
               bus.mem_addr  <= {{(INSTR_W-ADDR_W-2){1'b0}}, word_idx, 2'b00};
               bus.mem_wdata <= asm_next;
            end
         end
         if (state == WRITE && !last_word) begin
            word_idx <= word_idx + ADDR_W'(1);
            byte_idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: byte streams are checked against a
// word-level memory model built from the little-endian packing rule.
module tb_instr_loader;
   import instr_loader_pkg::*;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [ADDR_W:0] word_count;
   logic            busy;
   logic            done;
   logic            err;
   logic            cpu_hold;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] tb_mem    [DEPTH];
   logic [7:0]  stim_bytes[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   instr_loader_if bus ();

   instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .word_count (word_count),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   // Plays the instruction memory: records every write strobe seen.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
         tb_mem[bus.mem_addr[6:2]] = bus.mem_wdata;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_rx_ready"}, bus.rx_ready, 0);
      checkOutput({tag, "_mem_we"}, bus.mem_we, 0);
      checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
      checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_err"}, err, 0);
      checkOutput({tag, "_cpu_hold"}, cpu_hold, 1);
   endtask

   task automatic driveByte(inout int k, input int n, input int mode, input int cycles);
      bit v;
      case (mode)
         0:       v = 1'b1;
         1:       v = cycles[0];
         default: v = ($urandom_range(99) >= 30);
      endcase
      v = v && (k < 4*n);
      bus.rx_valid = v;
      bus.rx_data  = (k < 4*n) ? stim_bytes[k] : 8'h00;
      if (v && bus.rx_ready === 1'b1) k++;
   endtask

   // mode 0: continuous stream, 1: valid toggles every cycle, 2: random stalls.
   task automatic applyStimulus(input int n, input int mode, input bit poke_start);
      int          k;
      int          cycles;
      int          budget;
      bit          done_seen;
      bit          busy_drop;
      logic [31:0] w;
      while (stim_bytes.size() < 4*n) stim_bytes.push_back(8'($urandom));
      wr_addr.delete();
      wr_data.delete();
      k         = 0;
      cycles    = 0;
      done_seen = 0;
      busy_drop = 0;
      budget    = 40*n + 20;
      @(negedge clk);
      start      = 1'b1;
      word_count = (ADDR_W+1)'(n);
      driveByte(k, n, mode, cycles);
      while (!done_seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         start = poke_start && (cycles == 2);
         if (poke_start && cycles == 2) word_count = (ADDR_W+1)'(1);
         if (cycles == 1 && n > 0) checkOutput("hold_after_start", cpu_hold, 1);
         if (done === 1'b1) begin
            done_seen = 1;
         end else begin
            if (busy !== 1'b1) busy_drop = 1;
            if (bus.mem_we === 1'b1) checkOutput("ready_in_write", bus.rx_ready, 0);
            driveByte(k, n, mode, cycles);
         end
      end
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      checkOutput("done_reached", done_seen, 1);
      if (mode == 0) checkOutput("latency", cycles, 5*n + 1);
      checkOutput("cpu_hold_done", cpu_hold, 0);
      if (n > 0) checkOutput("busy_held", busy_drop, 0);
      checkOutput("write_count", wr_addr.size(), n);
      for (int i = 0; i < n; i++) begin
         w = 32'(stim_bytes[4*i]) + (32'(stim_bytes[4*i+1]) << 8)
           + (32'(stim_bytes[4*i+2]) << 16) + (32'(stim_bytes[4*i+3]) << 24);
         model_mem[i] = w;
         if (i < wr_addr.size()) begin
            checkOutput("waddr", wr_addr[i], 32'(4*i));
            checkOutput("wdata", wr_data[i], w);
         end
      end
      stim_bytes.delete();
   endtask

   task automatic checkReject(input int cnt, input bit in_done);
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      start      = 1'b1;
      word_count = (ADDR_W+1)'(cnt);
      @(negedge clk);
      start = 1'b0;
      checkOutput("err_pulse", err, 1);
      checkOutput("err_busy", busy, 0);
      checkOutput("err_done", done, in_done);
      checkOutput("err_hold", cpu_hold, !in_done);
      @(negedge clk);
      checkOutput("err_clear", err, 0);
      checkOutput("err_state", done, in_done);
      checkOutput("err_nowrite", wr_addr.size(), 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      word_count   = '0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = '0;
         tb_mem[i]    = '0;
      end
      repeat (3) @(negedge clk);
      checkReset("rst");
      rst_n = 1'b1;

      $display("[TB] oversize count from IDLE");
      checkReject(33, 1'b0);

      $display("[TB] single directed word");
      stim_bytes = {8'h13, 8'h05, 8'hA0, 8'h00};
      applyStimulus(1, 0, 1'b0);
      if (wr_data.size() > 0) checkOutput("directed_word", wr_data[0], 32'h00A00513);

      $display("[TB] three words, continuous");
      applyStimulus(3, 0, 1'b0);

      $display("[TB] toggling source");
      stim_bytes = {8'h13, 8'h05, 8'hA0, 8'h00};
      applyStimulus(1, 1, 1'b0);
      if (wr_data.size() > 0) checkOutput("stalled_word", wr_data[0], 32'h00A00513);

      $display("[TB] zero count and rejected start from DONE");
      applyStimulus(0, 0, 1'b0);
      checkReject(63, 1'b1);

      $display("[TB] full depth with random stalls");
      applyStimulus(DEPTH, 2, 1'b0);
      if (wr_addr.size() > 0) checkOutput("last_addr", wr_addr[$], 32'd124);

      $display("[TB] reload from DONE with stray start");
      applyStimulus(2, 0, 1'b1);

      $display("[TB] reset mid-load");
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      start      = 1'b1;
      word_count = (ADDR_W+1)'(2);
      @(negedge clk);
      start        = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      bus.rx_data = 8'($urandom);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      checkOutput("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      checkReset("rst_mid");
      @(negedge clk);
      checkOutput("rst_nowrite", wr_addr.size(), 0);
      rst_n = 1'b1;
      applyStimulus(4, 2, 1'b0);

      for (int i = 0; i < DEPTH; i++) begin
         checkOutput($sformatf("mem%0d", i), tb_mem[i], model_mem[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time writer for the CPU instruction memory. Accepts a little-endian byte stream over a valid/ready handshake, assembles the bytes into 32-bit instruction words, and writes them to consecutive word slots starting at byte address 0. Holds the CPU in reset until the programmed word count has been written. Sits between the host/debug byte source and the instruction memory write port; the memory's read side is unchanged and still indexed by `pc>>2`.

## Interface
- `DEPTH`, 32: instruction memory depth in words.
- `ADDR_W`, 5: word-index width, equal to log2(`DEPTH`).

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a load; sampled only in IDLE or DONE.
- `word_count`  in  ADDR_W+1: number of words to load; latched on an accepted `start`.
- `rx_valid`  in  1: byte-source data valid.
- `rx_data`  in  8: byte from the source.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `mem_we`  out  1: instruction memory write strobe, one cycle per word.
- `mem_addr`  out  32: byte address of the word being written, always a multiple of 4.
- `mem_wdata`  out  32: assembled instruction word.
- `busy`  out  1: high in LOAD and WRITE.
- `done`  out  1: high while in DONE.
- `err`  out  1: one-cycle pulse when `start` is rejected.
- `cpu_hold`  out  1: high keeps the CPU in reset.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: `rx_ready`=0, `cpu_hold`=1.
  - `start` with `word_count`==0 goes to DONE.
  - `start` with `word_count` > `DEPTH` pulses `err` and stays in IDLE.
  - Otherwise latch the count, clear `word_idx` and `byte_idx`, and go to LOAD.
- LOAD: `rx_ready`=1, `cpu_hold`=1.
  - On each handshake (`rx_valid` && `rx_ready`), `rx_data` goes into the assembly register at bits [8*byte_idx+7 : 8*byte_idx]. The first byte lands in [7:0].
  - `byte_idx` increments 0→3.
  - The handshake with `byte_idx`==3 loads the final byte and moves to WRITE.
- WRITE: `rx_ready`=0.
  - `mem_we`=1, `mem_addr`={word_idx,2'b00} zero-extended, `mem_wdata`=assembled word.
  - Next state: `word_idx`==count-1 goes to DONE; otherwise increment `word_idx`, clear `byte_idx`, and return to LOAD.
- DONE: `done`=1, `cpu_hold`=0, `rx_ready`=0.
  - A valid `start` reloads using the same rules as IDLE. `cpu_hold` reasserts in the cycle after `start` is accepted.
  - A rejected `start` pulses `err` and stays in DONE.
- `start` is ignored in LOAD and WRITE.
- Bytes presented while `rx_ready`=0 are not consumed. The source holds them.
- Words beyond `word_count` are never written. Memory contents above the last word are untouched.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert) gives:
  - state IDLE, `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `busy`=0, `done`=0, `err`=0, `cpu_hold`=1;
  - all counters 0.
- Reset asserted mid-load aborts immediately. The partial word is discarded and `mem_we` drops combinationally with the state.
- `mem_we`, `mem_addr` and `mem_wdata` are registered, valid in the single WRITE cycle. The memory captures on the next `clk` edge.
- Minimum load time is 5 cycles per word (4 byte handshakes plus 1 WRITE bubble), plus 1 cycle for `start`. N words with `rx_valid` held high reach DONE 5N+1 cycles after `start`.
- Source stalls (`rx_valid`=0) extend LOAD with no timeout.
- `err` is high only in the cycle after the rejected `start`.
- `word_count`==`DEPTH` is legal. The final `mem_addr`=4*(DEPTH-1)=124 for the default depth, and `word_idx` does not wrap past DEPTH-1.

## Structure
- Shared CPU package holds:
  - the state enum `loader_state_t` {IDLE, LOAD, WRITE, DONE};
  - the constants `INSTR_W`=32 and `BYTES_PER_INSTR`=4.
- No sub-modules needed: one FSM, one 2-bit byte counter, one word counter, one 32-bit assembly register.
- The instruction memory gains a write port (`we`, `waddr`, `wdata`) driven from this block. Its read path is unchanged.

## Test plan
- Single word: `start`, `word_count`=1, bytes 0x13,0x05,0xA0,0x00 → one `mem_we` with `mem_addr`=0, `mem_wdata`=0x00A00513. `done`=1 and `cpu_hold`=0 at cycle 6 after `start`.
- Three words, continuous stream of 12 bytes → writes at addresses 0, 4, 8 with correct little-endian words. `rx_ready` drops in each WRITE cycle. DONE at cycle 16.
- Stalled source: `rx_valid` toggling 1-0-1-0 across 4 bytes → same word as the continuous case. No extra writes; `busy` stays high throughout.
- Bounds:
  - `word_count`=33 → `err` pulse, state stays IDLE, no `mem_we`.
  - `word_count`=0 → DONE with no writes.
  - `word_count`=32 → last `mem_addr`=124.
- Reset mid-operation: `rst_n` low after 2 bytes of word 1 → all outputs at reset values immediately, and no `mem_we` for the partial word. A subsequent full load then succeeds.
- Reload from DONE: second `start` with `word_count`=2 → `cpu_hold` returns to 1 and new words overwrite addresses 0 and 4. `start` pulses during LOAD are ignored.
